// File: rtl/layer2_sequencer.sv
// Layer-2 sequencer: runs one N_HID x N_OUT multiply-accumulate pass into a
// single gSRAM row, then a sigmoid pass over the N_OUT accumulated outputs.
module layer2_sequencer #(
  parameter int N_HID   = 10,
  parameter int N_OUT   = 10,
  parameter int RD_LAT  = 1,
  parameter int SIG_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] slot,
  output logic       busy,
  output logic       done,
  output logic [4:0] reg_addr,
  output logic       reg_sel,
  output logic       acc_zero,
  output logic [3:0] w2_addr,
  output logic       w2_next_row,
  output logic [3:0] gsram_row,
  output logic [3:0] gsram_col,
  output logic       gsram_we,
  output logic       gsram_mux
);

  typedef enum logic [2:0] {
    IDLE,
    MAC_RD,
    MAC_WR,
    SIG_RD,
    SIG_WR,
    DONE
  } state_t;

  localparam logic [4:0] I_LAST   = 5'(N_HID - 1);
  localparam logic [3:0] J_LAST   = 4'(N_OUT - 1);
  localparam logic [2:0] MAC_HOLD = 3'(RD_LAT - 1);
  localparam logic [2:0] SIG_HOLD = 3'(RD_LAT + SIG_LAT - 1);

  state_t     state;
  logic [4:0] i;
  logic [3:0] j;
  logic [2:0] hold;
  logic       we_q;

  // Index counters are themselves the address registers; i is cleared on
  // entry to the sigmoid phase so reg_addr reads 0 there.
  assign reg_addr  = i;
  assign w2_addr   = j;
  assign gsram_col = j;

  // Abort must suppress the write in the very cycle it arrives.
  assign gsram_we  = we_q & ~abort;

  // Pass state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      hold        <= '0;
      we_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      reg_sel     <= 1'b0;
      acc_zero    <= 1'b0;
      w2_next_row <= 1'b0;
      gsram_row   <= '0;
      gsram_mux   <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      done        <= 1'b0;
      w2_next_row <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        i         <= '0;
        j         <= '0;
        hold      <= '0;
        busy      <= 1'b0;
        reg_sel   <= 1'b0;
        acc_zero  <= 1'b0;
        gsram_mux <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state     <= MAC_RD;
              gsram_row <= slot;
              i         <= '0;
              j         <= '0;
              hold      <= '0;
              busy      <= 1'b1;
              acc_zero  <= 1'b1;
              reg_sel   <= 1'b0;
              gsram_mux <= 1'b0;
            end
          end
          MAC_RD: begin
            if (hold == MAC_HOLD) begin
              state       <= MAC_WR;
              hold        <= '0;
              we_q        <= 1'b1;
              // Row-advance pulse coincides with the write that ends a row.
              w2_next_row <= (j == J_LAST) && (i != I_LAST);
            end else begin
              hold <= hold + 3'd1;
            end
          end
          MAC_WR: begin
            if (j != J_LAST) begin
              j     <= j + 4'd1;
              state <= MAC_RD;
            end else if (i != I_LAST) begin
              j        <= '0;
              i        <= i + 5'd1;
              acc_zero <= 1'b0;
              state    <= MAC_RD;
            end else begin
              j         <= '0;
              i         <= '0;
              acc_zero  <= 1'b0;
              reg_sel   <= 1'b1;
              gsram_mux <= 1'b1;
              state     <= SIG_RD;
            end
          end
          SIG_RD: begin
            if (hold == SIG_HOLD) begin
              state <= SIG_WR;
              hold  <= '0;
              we_q  <= 1'b1;
            end else begin
              hold <= hold + 3'd1;
            end
          end
          SIG_WR: begin
            if (j != J_LAST) begin
              j     <= j + 4'd1;
              state <= SIG_RD;
            end else begin
              j         <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              reg_sel   <= 1'b0;
              gsram_mux <= 1'b0;
              state     <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer2_sequencer.sv
// Self-checking bench for layer2_sequencer: three parameterisations share a
// clock; expected behaviour is derived per cycle from the pass timing rules.
module tb_layer2_sequencer;

  logic clk = 1'b0;
  logic reset;

  logic       start_i [3];
  logic       abort_i [3];
  logic [3:0] slot_i  [3];

  logic       busy_o     [3];
  logic       done_o     [3];
  logic [4:0] reg_addr_o [3];
  logic       reg_sel_o  [3];
  logic       acc_zero_o [3];
  logic [3:0] w2_addr_o  [3];
  logic       w2nr_o     [3];
  logic [3:0] row_o      [3];
  logic [3:0] col_o      [3];
  logic       we_o       [3];
  logic       mux_o      [3];

  int nh_p [3] = '{10, 2, 2};
  int no_p [3] = '{10, 3, 2};
  int rl_p [3] = '{1, 1, 2};
  int sg_p [3] = '{1, 1, 3};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  layer2_sequencer u_a (
    .clk(clk), .reset(reset), .start(start_i[0]), .abort(abort_i[0]), .slot(slot_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .reg_addr(reg_addr_o[0]), .reg_sel(reg_sel_o[0]),
    .acc_zero(acc_zero_o[0]), .w2_addr(w2_addr_o[0]), .w2_next_row(w2nr_o[0]),
    .gsram_row(row_o[0]), .gsram_col(col_o[0]), .gsram_we(we_o[0]), .gsram_mux(mux_o[0])
  );

  layer2_sequencer #(.N_HID(2), .N_OUT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_i[1]), .abort(abort_i[1]), .slot(slot_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .reg_addr(reg_addr_o[1]), .reg_sel(reg_sel_o[1]),
    .acc_zero(acc_zero_o[1]), .w2_addr(w2_addr_o[1]), .w2_next_row(w2nr_o[1]),
    .gsram_row(row_o[1]), .gsram_col(col_o[1]), .gsram_we(we_o[1]), .gsram_mux(mux_o[1])
  );

  layer2_sequencer #(.N_HID(2), .N_OUT(2), .RD_LAT(2), .SIG_LAT(3)) u_c (
    .clk(clk), .reset(reset), .start(start_i[2]), .abort(abort_i[2]), .slot(slot_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .reg_addr(reg_addr_o[2]), .reg_sel(reg_sel_o[2]),
    .acc_zero(acc_zero_o[2]), .w2_addr(w2_addr_o[2]), .w2_next_row(w2nr_o[2]),
    .gsram_row(row_o[2]), .gsram_col(col_o[2]), .gsram_we(we_o[2]), .gsram_mux(mux_o[2])
  );

  task automatic chk(input string tag, input int k, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, c, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out(input int k);
    return 32'({busy_o[k], done_o[k], reg_addr_o[k], reg_sel_o[k], acc_zero_o[k],
                w2_addr_o[k], w2nr_o[k], row_o[k], col_o[k], we_o[k], mux_o[k]});
  endfunction

  // One pass on instance k; abort_at >= 0 asserts abort during that cycle index
  // (cycle 0 is the first cycle after the start-accepting edge).
  task automatic run_pass(input int k, input int abort_at);
    int nh, no, rl, sg, mac_len, total, last, n, ph, i, j, m;
    int n_mac_we, n_sig_we;
    logic [3:0] sv;
    logic e_busy, e_done, e_we, e_w2nr, in_mac, in_sig;
    nh = nh_p[k]; no = no_p[k]; rl = rl_p[k]; sg = sg_p[k];
    mac_len = nh * no * (rl + 1);
    total   = mac_len + no * (rl + sg + 1);
    last    = (abort_at >= 0) ? abort_at + 4 : total + 2;
    sv      = 4'($urandom_range(0, 15));
    n_mac_we = 0; n_sig_we = 0;
    @(posedge clk); #1;
    start_i[k] = 1'b1; slot_i[k] = sv; abort_i[k] = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      start_i[k] = (c < total && (abort_at < 0 || c < abort_at)) ? 1'($urandom_range(0, 1)) : 1'b0;
      slot_i[k]  = 4'($urandom_range(0, 15));
      abort_i[k] = (c == abort_at);
      @(negedge clk);
      e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_w2nr = 1'b0;
      in_mac = 1'b0; in_sig = 1'b0; i = 0; j = 0; m = 0;
      if (abort_at >= 0 && c > abort_at) begin
        // aborted: idle from here on
      end else if (c < mac_len) begin
        n = c / (rl + 1); ph = c % (rl + 1); i = n / no; j = n % no;
        in_mac = 1'b1; e_busy = 1'b1;
        e_we   = (ph == rl) && (c != abort_at);
        e_w2nr = (ph == rl) && (j == no - 1) && (i < nh - 1);
      end else if (c < total) begin
        m = (c - mac_len) / (rl + sg + 1); ph = (c - mac_len) % (rl + sg + 1);
        in_sig = 1'b1; e_busy = 1'b1;
        e_we   = (ph == rl + sg) && (c != abort_at);
      end else if (c == total) begin
        e_done = 1'b1;
      end
      chk("busy", k, c, 32'(busy_o[k]), 32'(e_busy));
      chk("done", k, c, 32'(done_o[k]), 32'(e_done));
      chk("gsram_we", k, c, 32'(we_o[k]), 32'(e_we));
      chk("w2_next_row", k, c, 32'(w2nr_o[k]), 32'(e_w2nr));
      if (e_busy) chk("gsram_row", k, c, 32'(row_o[k]), 32'(sv));
      if (in_mac) begin
        chk("reg_addr", k, c, 32'(reg_addr_o[k]), 32'(i));
        chk("w2_addr", k, c, 32'(w2_addr_o[k]), 32'(j));
        chk("gsram_col_mac", k, c, 32'(col_o[k]), 32'(j));
        chk("acc_zero", k, c, 32'(acc_zero_o[k]), 32'(i == 0));
        chk("reg_sel_mac", k, c, 32'(reg_sel_o[k]), 32'd0);
      end
      if (in_sig) begin
        chk("gsram_col_sig", k, c, 32'(col_o[k]), 32'(m));
        chk("reg_sel_sig", k, c, 32'(reg_sel_o[k]), 32'd1);
        chk("acc_zero_sig", k, c, 32'(acc_zero_o[k]), 32'd0);
      end
      if (e_we) chk("gsram_mux", k, c, 32'(mux_o[k]), 32'(in_sig));
      if (we_o[k] === 1'b1 && mux_o[k] === 1'b0) n_mac_we++;
      if (we_o[k] === 1'b1 && mux_o[k] === 1'b1) n_sig_we++;
    end
    if (abort_at < 0) begin
      chk("mac_write_count", k, last, 32'(n_mac_we), 32'(nh * no));
      chk("sig_write_count", k, last, 32'(n_sig_we), 32'(no));
    end
    start_i[k] = 1'b0; abort_i[k] = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_i[k] = 1'b0; abort_i[k] = 1'b0; slot_i[k] = '0;
    end

    // Reset held, then released with no start.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("reset_outputs", k, 0, all_out(k), 32'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("idle_outputs", k, c, all_out(k), 32'd0);
    end

    // Directed passes on each parameterisation.
    run_pass(0, -1);
    run_pass(1, -1);
    run_pass(2, -1);

    // Abort in MAC_WR at i=3, j=4 (write index 34), then a full pass.
    run_pass(0, 34 * 2 + 1);
    run_pass(0, -1);

    // start and abort together in IDLE: stays idle.
    @(posedge clk); #1;
    start_i[0] = 1'b1; abort_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0; abort_i[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("collide_busy", 0, c, 32'(busy_o[0]), 32'd0);
      chk("collide_we", 0, c, 32'(we_o[0]), 32'd0);
    end

    // Asynchronous reset during SIG_RD on instance B (sigmoid starts at cycle 12).
    @(posedge clk); #1;
    start_i[1] = 1'b1; slot_i[1] = 4'd9;
    @(posedge clk); #1;
    start_i[1] = 1'b0;
    for (int c = 1; c <= 12; c++) @(posedge clk);
    #1;
    chk("pre_reset_sig", 1, 12, 32'({busy_o[1], reg_sel_o[1]}), 32'h3);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset", 1, 12, all_out(1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", 1, 13, all_out(1), 32'd0);

    // Randomised extra passes and aborts.
    for (int r = 0; r < 4; r++) begin
      run_pass(int'($urandom_range(1, 2)), -1);
      run_pass(1, int'($urandom_range(0, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
